// File: rtl/imu_pkg.sv
// imu_pkg: shared types and constants for the inertial-sensor interface.
//   - seq_state_t : sequencer states of inert_intf
//   - spi_state_t : transaction states of imu_spi_mnrch
//   - CFG_CMDS    : power-up configuration writes, issued in index order
//   - RD_CMDS     : per-interrupt read burst (pitch L/H, AZ L/H)
//   - SYNC_DEPTH  : flop count of the INT synchronizer
package imu_pkg;

  localparam int unsigned SYNC_DEPTH = 2;
  localparam int unsigned N_CMDS     = 4;

  typedef enum logic [2:0] {
    INIT_WAIT,
    CFG,
    WAIT_INT,
    RD,
    VLD
  } seq_state_t;

  typedef enum logic [1:0] {
    IDLE,
    FRONT,
    SHIFT,
    BACK
  } spi_state_t;

  // INT on data-ready, accel 208 Hz +/-2 g, gyro 208 Hz +/-245 dps, rounding on
  localparam logic [15:0] CFG_CMDS [N_CMDS] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  // pitch-rate L, pitch-rate H, Z-accel L, Z-accel H
  localparam logic [15:0] RD_CMDS  [N_CMDS] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  function automatic logic [15:0] cmd_sel(input logic rd, input logic [1:0] idx);
    return rd ? RD_CMDS[idx] : CFG_CMDS[idx];
  endfunction

endpackage

// File: rtl/imu_spi_mnrch.sv
// imu_spi_mnrch: SPI mode-3 master, one 16-bit MSB-first transaction per wrt.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   wrt            : one-cycle start strobe; cmd is latched on it
//   cmd[15:0]      : word shifted out on MOSI
//   MISO           : serial data from slave, sampled on SCLK rise
//   SS_n, SCLK     : slave select (active-low) and serial clock (idles high)
//   MOSI           : serial data to slave, changes on SCLK fall
//   done           : one-cycle strobe, same cycle SS_n rises
//   rd_data[15:0]  : word received during the last transaction
module imu_spi_mnrch #(
  parameter int unsigned SCLK_DIV_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);
  import imu_pkg::*;

  localparam logic [SCLK_DIV_BITS-1:0] DIV_ONE = SCLK_DIV_BITS'(1);
  // Divider value on the last clk of the SCLK-low half; next edge raises SCLK.
  localparam logic [SCLK_DIV_BITS-1:0] RISE_AT = SCLK_DIV_BITS'((1 << (SCLK_DIV_BITS - 1)) - 1);

  spi_state_t               state, nxt;
  logic [SCLK_DIV_BITS-1:0] div_cnt;
  logic [3:0]               bit_cnt;
  logic [15:0]              shft;
  logic                     miso_smpl;
  logic                     rise, wrap;
  logic                     ld, sclk_fall, smpl, shft_en, fin;

  assign rise = (div_cnt == RISE_AT);
  assign wrap = (div_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (wrt) nxt = FRONT;
      FRONT:   nxt = SHIFT;
      SHIFT:   if (rise && bit_cnt == 4'd15) nxt = BACK;
      BACK:    if (wrap) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ld        = 1'b0;
    sclk_fall = 1'b0;
    smpl      = 1'b0;
    shft_en   = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE:  ld = wrt;
      FRONT: sclk_fall = 1'b1;
      SHIFT: begin
        smpl      = rise;
        sclk_fall = wrap;
        shft_en   = wrap;
      end
      BACK: begin
        // Half period after the 16th rise: last shift, release SS_n.
        shft_en = wrap;
        fin     = wrap;
      end
      default: ;
    endcase
  end

  // The first SCLK fall (entry to SHIFT) only starts the clock: bit 15 is
  // already on MOSI, so shifting begins on the second fall. Each shift pulls
  // in the MISO bit captured on the preceding rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n      <= 1'b1;
      SCLK      <= 1'b1;
      done      <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shft      <= '0;
      miso_smpl <= 1'b0;
    end else begin
      done <= fin;
      if (ld) begin
        SS_n    <= 1'b0;
        shft    <= cmd;
        bit_cnt <= '0;
      end
      if (fin) SS_n <= 1'b1;
      if (state == FRONT) div_cnt <= '0;
      else                div_cnt <= div_cnt + DIV_ONE;
      if (sclk_fall)  SCLK <= 1'b0;
      else if (smpl)  SCLK <= 1'b1;
      if (smpl) begin
        miso_smpl <= MISO;
        bit_cnt   <= bit_cnt + 4'd1;
      end
      if (shft_en) shft <= {shft[14:0], miso_smpl};
    end
  end

  assign MOSI    = shft[15];
  assign rd_data = shft;

endmodule

// File: rtl/inert_intf.sv
// inert_intf: IMU sequencer. Waits 2^INIT_WAIT_BITS clk after reset, writes
// four config commands, then on every (synchronized, level) INT reads pitch
// rate and Z accel bytes and presents them with a one-cycle vld.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   INT              : IMU data-ready, asynchronous, active-high level
//   MISO             : SPI data from IMU
//   SS_n, SCLK, MOSI : SPI master outputs (mode 3)
//   vld              : one-cycle strobe, ptch_rt/AZ updated
//   ptch_rt[15:0]    : raw pitch rate {H,L}
//   AZ[15:0]         : raw Z acceleration {H,L}
module inert_intf #(
  parameter int unsigned INIT_WAIT_BITS = 16,
  parameter int unsigned SCLK_DIV_BITS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);
  import imu_pkg::*;

  localparam logic [INIT_WAIT_BITS-1:0] INIT_ONE = INIT_WAIT_BITS'(1);

  seq_state_t                state, nxt;
  logic [SYNC_DEPTH-1:0]     int_sync;
  logic                      int_s;
  logic [INIT_WAIT_BITS-1:0] init_cnt;
  logic [1:0]                idx;
  logic                      wrt, done, issue;
  logic [15:0]               cmd, rd_data;
  logic [7:0]                rd_hi_unused;
  logic [7:0]                ptch_l, ptch_h, az_l;

  assign int_s        = int_sync[SYNC_DEPTH-1];
  assign rd_hi_unused = rd_data[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_sync <= '0;
    else        int_sync <= {int_sync[SYNC_DEPTH-2:0], INT};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT_WAIT;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      INIT_WAIT: if (&init_cnt) nxt = CFG;
      CFG:       if (done && idx == 2'd3) nxt = WAIT_INT;
      WAIT_INT:  if (int_s) nxt = RD;
      RD:        if (done && idx == 2'd3) nxt = VLD;
      VLD:       nxt = WAIT_INT;
      default:   nxt = INIT_WAIT;
    endcase
  end

  // A command is due on entry to CFG/RD and after every non-final done.
  always_comb begin
    vld   = (state == VLD);
    issue = (nxt == CFG || nxt == RD) && (state != nxt || done);
  end

  assign cmd = cmd_sel(state == RD, idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '0;
      idx      <= '0;
      wrt      <= 1'b0;
      ptch_l   <= '0;
      ptch_h   <= '0;
      az_l     <= '0;
      ptch_rt  <= '0;
      AZ       <= '0;
    end else begin
      wrt <= issue;
      if (state == INIT_WAIT) init_cnt <= init_cnt + INIT_ONE;
      if (state != nxt)       idx <= '0;
      else if (done)          idx <= idx + 2'd1;
      if (state == RD && done) begin
        case (idx)
          2'd0:    ptch_l <= rd_data[7:0];
          2'd1:    ptch_h <= rd_data[7:0];
          2'd2:    az_l   <= rd_data[7:0];
          default: ;
        endcase
      end
      // Outputs load on the edge into VLD so they are new in the vld cycle;
      // the AZ high byte comes straight from the final transaction.
      if (state == RD && nxt == VLD) begin
        ptch_rt <= {ptch_h, ptch_l};
        AZ      <= {rd_data[7:0], az_l};
      end
    end
  end

  imu_spi_mnrch #(
    .SCLK_DIV_BITS(SCLK_DIV_BITS)
  ) u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrt    (wrt),
    .cmd    (cmd),
    .MISO   (MISO),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .done   (done),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_inert_intf.sv
module tb_inert_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, vld;
  logic [15:0] ptch_rt, AZ;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inert_intf #(
    .INIT_WAIT_BITS(6),
    .SCLK_DIV_BITS (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .INT    (INT),
    .MISO   (MISO),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .vld    (vld),
    .ptch_rt(ptch_rt),
    .AZ     (AZ)
  );

  // Command words the IMU must see, straight from the device setup table.
  logic [15:0] cfg_exp [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] rd_exp  [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  // ---------------- SPI slave model (mode 3, MSB first) ----------------
  logic [15:0] miso_q [$];
  logic [15:0] mosi_q [$];
  logic [15:0] tx, rx;
  int          nbits = 0;
  int          bad_len = 0;

  always @(negedge SS_n) begin
    if (miso_q.size() > 0) tx = miso_q.pop_front();
    else                   tx = 16'($urandom);
    rx    = '0;
    nbits = 0;
    MISO  = tx[15];
  end
  always @(posedge SCLK) if (SS_n === 1'b0) begin
    rx = {rx[14:0], MOSI};
    nbits++;
  end
  always @(negedge SCLK) if (SS_n === 1'b0 && nbits > 0 && nbits < 16) MISO = tx[15-nbits];
  always @(posedge SS_n) if (rst_n === 1'b1) begin
    mosi_q.push_back(rx);
    if (nbits != 16) bad_len++;
  end

  // ---------------- passive monitors ----------------
  int          vld_cnt = 0, hold_viol = 0, gap = 0, min_gap = 1000;
  bit          seen_txn = 1'b0;
  logic [15:0] prev_p = '0, prev_a = '0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_p = '0; prev_a = '0; gap = 0; seen_txn = 1'b0;
    end else begin
      if (vld === 1'b1) vld_cnt++;
      else if (ptch_rt !== prev_p || AZ !== prev_a) hold_viol++;
      prev_p = ptch_rt;
      prev_a = AZ;
      if (SS_n === 1'b1) gap++;
      else begin
        if (gap > 0) begin
          if (seen_txn && gap < min_gap) min_gap = gap;
          seen_txn = 1'b1;
        end
        gap = 0;
      end
    end
  end

  // ---------------- reference model of read results ----------------
  logic [15:0] exp_p [$];
  logic [15:0] exp_a [$];

  task automatic push_burst(input logic [7:0] pl, ph, al, ah);
    // Data byte returns in the low byte; the high byte is don't-care filler.
    miso_q.push_back({8'($urandom), pl});
    miso_q.push_back({8'($urandom), ph});
    miso_q.push_back({8'($urandom), al});
    miso_q.push_back({8'($urandom), ah});
    exp_p.push_back({ph, pl});
    exp_a.push_back({ah, al});
  endtask

  task automatic push_rand_burst();
    push_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ss_fall(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (SS_n !== 1'b0 && n < 3000);
  endtask

  task automatic wait_words(input int k);
    int n = 0;
    while (mosi_q.size() < k && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("word_count_%0d", k), mosi_q.size(), k);
  endtask

  task automatic wait_vld_and_check(input string tag);
    int          n = 0;
    logic [15:0] ep, ea;
    do begin
      @(negedge clk);
      n++;
    end while (vld !== 1'b1 && n < 3000);
    chk({tag, "_vld_seen"}, vld, 1'b1);
    ep = (exp_p.size() > 0) ? exp_p.pop_front() : 16'hDEAD;
    ea = (exp_a.size() > 0) ? exp_a.pop_front() : 16'hBEEF;
    chk({tag, "_ptch_rt"}, ptch_rt, ep);
    chk({tag, "_AZ"}, AZ, ea);
  endtask

  task automatic check_words(input string tag, input int base, input bit rd);
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w = (base + i < mosi_q.size()) ? mosi_q[base+i] : 16'hFFFF;
      chk($sformatf("%s_word%0d", tag, i), w, rd ? rd_exp[i] : cfg_exp[i]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    int          base;
    logic [15:0] keep_p, keep_a;

    repeat (3) @(negedge clk);
    chk("rst_SS_n", SS_n, 1'b1);
    chk("rst_SCLK", SCLK, 1'b1);
    chk("rst_MOSI", MOSI, 1'b0);
    chk("rst_vld", vld, 1'b0);
    chk("rst_ptch_rt", ptch_rt, 16'h0000);
    chk("rst_AZ", AZ, 16'h0000);

    // Power-up: 63 clk to reach all-ones, 1 into CFG (wrt), 1 to SS_n fall.
    rst_n = 1'b1;
    wait_ss_fall(n);
    chk("init_latency", n, 65);
    wait_words(4);
    check_words("cfg", 0, 1'b0);
    chk("cfg_no_vld", vld_cnt, 0);

    // Single read with fixed data. INT->SS_n fall = 2 sync + 1 FSM + 1 wrt.
    mosi_q.delete();
    push_burst(8'h34, 8'h12, 8'hCD, 8'hAB);
    repeat (5) @(negedge clk);
    INT = 1'b1;
    wait_ss_fall(n);
    chk("int_latency", n, 4);
    INT = 1'b0;
    wait_vld_and_check("single");
    repeat (400) @(negedge clk);
    chk("single_vld_count", vld_cnt, 1);
    chk("single_hold_ptch", ptch_rt, 16'h1234);
    chk("single_hold_AZ", AZ, 16'hABCD);
    check_words("single_rd", 0, 1'b1);
    chk("single_word_total", mosi_q.size(), 4);

    // Second burst with random data; monitor flags any change outside vld.
    mosi_q.delete();
    push_rand_burst();
    keep_p = exp_p[0];
    keep_a = exp_a[0];
    INT = 1'b1;
    repeat (5) @(negedge clk);
    INT = 1'b0;
    wait_vld_and_check("second");
    repeat (50) @(negedge clk);
    chk("second_hold_ptch", ptch_rt, keep_p);
    chk("second_hold_AZ", AZ, keep_a);
    chk("second_hold_viol", hold_viol, 0);
    check_words("second_rd", 0, 1'b1);

    // INT held high: back-to-back bursts, released once the third starts.
    mosi_q.delete();
    base = vld_cnt;
    for (int b = 0; b < 3; b++) push_rand_burst();
    INT = 1'b1;
    wait_vld_and_check("held0");
    wait_vld_and_check("held1");
    wait_ss_fall(n);
    INT = 1'b0;
    wait_vld_and_check("held2");
    repeat (1500) @(negedge clk);
    chk("held_vld_count", vld_cnt - base, 3);
    chk("held_word_total", mosi_q.size(), 12);
    for (int b = 0; b < 3; b++) check_words($sformatf("held%0d_rd", b), 4 * b, 1'b1);
    chk("held_min_gap_ok", (min_gap >= 1) ? 1 : 0, 1);
    chk("held_hold_viol", hold_viol, 0);

    // Reset during the third read transaction; INT stays high through reset.
    mosi_q.delete();
    push_rand_burst();
    INT = 1'b1;
    wait_words(2);
    wait_ss_fall(n);
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_SS_n", SS_n, 1'b1);
    chk("midrst_SCLK", SCLK, 1'b1);
    chk("midrst_vld", vld, 1'b0);
    chk("midrst_ptch_rt", ptch_rt, 16'h0000);
    chk("midrst_AZ", AZ, 16'h0000);
    miso_q.delete();
    mosi_q.delete();
    exp_p.delete();
    exp_a.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ss_fall(n);
    chk("reinit_latency", n, 65);
    wait_words(4);
    push_rand_burst();
    check_words("reinit_cfg", 0, 1'b0);
    wait_ss_fall(n);
    INT = 1'b0;
    wait_vld_and_check("post_rst");
    wait_words(8);
    check_words("post_rst_rd", 4, 1'b1);
    repeat (300) @(negedge clk);
    chk("spi_len_errors", bad_len, 0);
    chk("final_hold_viol", hold_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
